// File: rtl/rf_exec_if.sv
// rtl/rf_exec_if.sv - command handshake and register-file bus of the exec controller
interface rf_exec_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 3
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_dst;
   logic [ADDR_W-1:0] cmd_src1;
   logic [ADDR_W-1:0] cmd_src2;
   logic [DATA_W-1:0] cmd_imm;
   logic [ADDR_W-1:0] rf_ad1;
   logic [ADDR_W-1:0] rf_ad2;
   logic [DATA_W-1:0] rf_d1;
   logic [DATA_W-1:0] rf_d2;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_wad;
   logic [DATA_W-1:0] rf_wd;
   logic              done;
   logic [DATA_W-1:0] result;
   logic              carry;

   // master is the controller; slave is the command source plus register file
   modport master (
      input  cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm, rf_d1, rf_d2,
      output cmd_ready, rf_ad1, rf_ad2, rf_we, rf_wad, rf_wd, done, result, carry
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm, rf_d1, rf_d2,
      input  cmd_ready, rf_ad1, rf_ad2, rf_we, rf_wad, rf_wd, done, result, carry
   );
endinterface

// File: rtl/rf_exec_controller.sv
// rtl/rf_exec_controller.sv - register-transfer command sequencer for the 8x4 register file
module rf_exec_controller #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 3
) (
   input logic       clk,
   input logic       reset,
   rf_exec_if.master bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, EXEC, WRITE} state_t;

   localparam logic [1:0] OP_LDI = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;

   state_t state, next_state;
   logic   accept;

   logic [1:0]        op_q;
   logic [ADDR_W-1:0] dst_q;

   logic              cmd_ready_q, cmd_ready_d;
   logic              rf_we_q, rf_we_d;
   logic              done_q, done_d;
   logic              carry_q, carry_d;
   logic [ADDR_W-1:0] rf_ad1_q, rf_ad1_d;
   logic [ADDR_W-1:0] rf_ad2_q, rf_ad2_d;
   logic [ADDR_W-1:0] rf_wad_q, rf_wad_d;
   logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;

   // cmd_ready_q gates acceptance so nothing is taken on the first edge after reset
   assign accept = (state == IDLE) && cmd_ready_q && bus.cmd_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = (bus.cmd_op == OP_LDI) ? WRITE : ISSUE;
         ISSUE:   next_state = EXEC;
         EXEC:    next_state = WRITE;
         WRITE:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready_d = (next_state == IDLE);
      rf_we_d     = 1'b0;
      done_d      = 1'b0;
      rf_ad1_d    = rf_ad1_q;
      rf_ad2_d    = rf_ad2_q;
      rf_wad_d    = rf_wad_q;
      rf_wd_d     = rf_wd_q;
      result_d    = result_q;
      carry_d     = carry_q;
      sum         = {1'b0, bus.rf_d1} + {1'b0, bus.rf_d2};
      diff        = {1'b0, bus.rf_d1} - {1'b0, bus.rf_d2};
      case (state)
         IDLE: begin
            if (accept) begin
               if (bus.cmd_op == OP_LDI) begin
                  rf_we_d  = 1'b1;
                  done_d   = 1'b1;
                  rf_wad_d = bus.cmd_dst;
                  rf_wd_d  = bus.cmd_imm;
                  result_d = bus.cmd_imm;
                  carry_d  = 1'b0;
               end else begin
                  rf_ad1_d = bus.cmd_src1;
                  rf_ad2_d = bus.cmd_src2;
               end
            end
         end
         EXEC: begin
            rf_we_d  = 1'b1;
            done_d   = 1'b1;
            rf_wad_d = dst_q;
            // the top bit of the widened difference is the borrow
            case (op_q)
               OP_ADD:  {carry_d, result_d} = sum;
               OP_SUB:  {carry_d, result_d} = diff;
               default: begin
                  result_d = bus.rf_d1;
                  carry_d  = 1'b0;
               end
            endcase
            rf_wd_d = result_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q        <= '0;
         dst_q       <= '0;
         cmd_ready_q <= 1'b0;
         rf_we_q     <= 1'b0;
         done_q      <= 1'b0;
         carry_q     <= 1'b0;
         rf_ad1_q    <= '0;
         rf_ad2_q    <= '0;
         rf_wad_q    <= '0;
         rf_wd_q     <= '0;
         result_q    <= '0;
      end else begin
         if (accept) begin
            op_q  <= bus.cmd_op;
            dst_q <= bus.cmd_dst;
         end
         cmd_ready_q <= cmd_ready_d;
         rf_we_q     <= rf_we_d;
         done_q      <= done_d;
         carry_q     <= carry_d;
         rf_ad1_q    <= rf_ad1_d;
         rf_ad2_q    <= rf_ad2_d;
         rf_wad_q    <= rf_wad_d;
         rf_wd_q     <= rf_wd_d;
         result_q    <= result_d;
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rf_we     = rf_we_q;
   assign bus.done      = done_q;
   assign bus.carry     = carry_q;
   assign bus.rf_ad1    = rf_ad1_q;
   assign bus.rf_ad2    = rf_ad2_q;
   assign bus.rf_wad    = rf_wad_q;
   assign bus.rf_wd     = rf_wd_q;
   assign bus.result    = result_q;
endmodule

// File: tb/tb_rf_exec_controller.sv
// tb/tb_rf_exec_controller.sv - randomized bench for rf_exec_controller with a transaction-level model
module tb_rf_exec_controller;
   localparam int DW   = 4;
   localparam int AW   = 3;
   localparam int MASK = (1 << DW) - 1;
   localparam int LDI  = 0;
   localparam int ADD  = 1;
   localparam int SUB  = 2;
   localparam int MOV  = 3;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   rf_exec_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   rf_exec_controller #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // register file: one-cycle registered read, write committed at the edge
   logic [DW-1:0] mem [8] = '{default: '0};
   always @(posedge clk) begin
      if (bus.rf_we) mem[bus.rf_wad] <= bus.rf_wd;
      bus.rf_d1 <= mem[bus.rf_ad1];
      bus.rf_d2 <= mem[bus.rf_ad2];
   end

   // reference: register contents plus a countdown to the write of the pending command
   int ref_regs [8] = '{default: 0};
   int exp_ready = 0, exp_we = 0, exp_done = 0, exp_wad = 0, exp_wd = 0;
   int exp_result = 0, exp_carry = 0, exp_ad1 = 0, exp_ad2 = 0;
   int pend = 0, wait_n = 0, p_dst = 0, p_val = 0, p_carry = 0;

   always @(posedge clk or posedge reset) begin
      int a, b, v, c;
      if (reset) begin
         exp_ready = 0; exp_we = 0; exp_done = 0; exp_wad = 0; exp_wd = 0;
         exp_result = 0; exp_carry = 0; exp_ad1 = 0; exp_ad2 = 0; pend = 0;
      end else begin
         if (exp_we != 0) ref_regs[exp_wad] = exp_wd;
         exp_we   = 0;
         exp_done = 0;
         if (pend != 0) begin
            wait_n--;
            if (wait_n == 0) begin
               pend = 0;
               exp_we = 1; exp_done = 1; exp_wad = p_dst; exp_wd = p_val;
               exp_result = p_val; exp_carry = p_carry;
            end
         end else if (exp_ready != 0 && bus.cmd_valid) begin
            a = ref_regs[int'(bus.cmd_src1)];
            b = ref_regs[int'(bus.cmd_src2)];
            case (int'(bus.cmd_op))
               LDI:     begin v = int'(bus.cmd_imm); c = 0; end
               ADD:     begin v = (a + b) & MASK; c = (a + b > MASK) ? 1 : 0; end
               SUB:     begin v = (a - b) & MASK; c = (a < b) ? 1 : 0; end
               default: begin v = a; c = 0; end
            endcase
            if (int'(bus.cmd_op) == LDI) begin
               exp_we = 1; exp_done = 1; exp_wad = int'(bus.cmd_dst); exp_wd = v;
               exp_result = v; exp_carry = c;
            end else begin
               pend = 1; wait_n = 2; p_dst = int'(bus.cmd_dst); p_val = v; p_carry = c;
               exp_ad1 = int'(bus.cmd_src1);
               exp_ad2 = int'(bus.cmd_src2);
            end
         end
         exp_ready = (pend != 0 || exp_we != 0) ? 0 : 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cmd_ready", bus.cmd_ready, exp_ready);
         chk("rf_we", bus.rf_we, exp_we);
         chk("done", bus.done, exp_done);
         chk("rf_ad1", bus.rf_ad1, exp_ad1);
         chk("rf_ad2", bus.rf_ad2, exp_ad2);
         chk("rf_wad", bus.rf_wad, exp_wad);
         chk("rf_wd", bus.rf_wd, exp_wd);
         chk("result", bus.result, exp_result);
         chk("carry", bus.carry, exp_carry);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // returns one cycle after the accepting edge, with cmd_valid still high
   task automatic send(input int op, input int dst, input int s1, input int s2, input int imm);
      bit ok = 1'b0;
      bus.cmd_op   = 2'(op);
      bus.cmd_dst  = AW'(dst);
      bus.cmd_src1 = AW'(s1);
      bus.cmd_src2 = AW'(s2);
      bus.cmd_imm  = DW'(imm);
      bus.cmd_valid = 1'b1;
      for (int k = 0; k < 20 && !ok; k++) begin
         ok = (bus.cmd_ready === 1'b1);
         step(1);
      end
      chk("accept_timeout", ok, 1);
   endtask

   task automatic cmd(input int op, input int dst, input int s1, input int s2, input int imm);
      send(op, dst, s1, s2, imm);
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op = '0; bus.cmd_dst = '0; bus.cmd_src1 = '0; bus.cmd_src2 = '0; bus.cmd_imm = '0;
      #1 reset = 1'b1;
      #1 cmp_en = 1'b1;
      bus.cmd_op = 2'(LDI); bus.cmd_dst = 3'd5; bus.cmd_imm = 4'd9; bus.cmd_valid = 1'b1;
      step(3);
      chk("rst_ready", bus.cmd_ready, 0);
      chk("rst_we", bus.rf_we, 0);
      reset = 1'b0;
      step(1);
      chk("ready_after_rst", bus.cmd_ready, 1);

      cmd(LDI, 5, 0, 0, 9);
      chk("ldi_we", bus.rf_we, 1);
      chk("ldi_wad", bus.rf_wad, 5);
      chk("ldi_wd", bus.rf_wd, 9);
      chk("ldi_done", bus.done, 1);
      chk("ldi_carry", bus.carry, 0);

      cmd(MOV, 0, 5, 0, 0);
      step(2);
      chk("mov_wad", bus.rf_wad, 0);
      chk("mov_wd", bus.rf_wd, 9);
      chk("mov_done", bus.done, 1);

      cmd(LDI, 2, 0, 0, 2);
      cmd(LDI, 3, 0, 0, 3);
      cmd(ADD, 6, 2, 3, 0);
      chk("add_ad1", bus.rf_ad1, 2);
      chk("add_ad2", bus.rf_ad2, 3);
      chk("add_busy", bus.cmd_ready, 0);
      step(2);
      chk("add_wad", bus.rf_wad, 6);
      chk("add_wd", bus.rf_wd, 5);
      chk("add_carry", bus.carry, 0);

      cmd(LDI, 4, 0, 0, 12);
      cmd(ADD, 7, 4, 4, 0);
      step(2);
      chk("add_ovf_wd", bus.rf_wd, 8);
      chk("add_ovf_carry", bus.carry, 1);
      cmd(LDI, 1, 0, 0, 1);
      cmd(SUB, 1, 1, 3, 0);
      step(2);
      chk("sub_wd", bus.rf_wd, 14);
      chk("sub_borrow", bus.carry, 1);

      send(LDI, 2, 0, 0, 7);
      send(MOV, 3, 2, 0, 0);
      step(2);
      chk("b2b_wd", bus.rf_wd, 7);
      chk("b2b_wad", bus.rf_wad, 3);
      bus.cmd_valid = 1'b0;

      cmd(LDI, 0, 0, 0, 6);
      reset = 1'b1;
      #1;
      chk("we_async_drop", bus.rf_we, 0);
      chk("done_async_drop", bus.done, 0);
      step(1);
      reset = 1'b0;
      step(1);
      chk("r0_kept", mem[0], 9);

      cmd(ADD, 6, 2, 3, 0);
      step(1);
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(1);
      chk("r6_kept", mem[6], 5);
      cmd(ADD, 6, 2, 3, 0);
      step(2);
      chk("after_rst_wd", bus.rf_wd, 14);
      chk("after_rst_we", bus.rf_we, 1);

      for (int i = 0; i < 300; i++) begin
         cmd($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 15));
         if ($urandom_range(0, 29) == 0) begin
            step($urandom_range(0, 2));
            reset = 1'b1;
            step($urandom_range(1, 2));
            reset = 1'b0;
         end else begin
            step($urandom_range(0, 4));
         end
      end
      step(4);
      cmp_en = 1'b0;
      for (int i = 0; i < 8; i++) chk("regfile", mem[i], ref_regs[i]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
